// File: rtl/cmp_flag_unit.sv
// cmp_flag_unit: captures a comparator flag triple and evaluates a branch condition from it.
// It also tracks non-one-hot triples in a sticky error flag and counts accepted compares.
module cmp_flag_unit #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_cmp_valid,
    output logic                 o_cmp_ready,
    input  logic                 i_cmp_equal,
    input  logic                 i_cmp_lower,
    input  logic                 i_cmp_greater,
    input  logic [2:0]           i_cond_code,
    input  logic                 i_flag_clear,
    output logic [2:0]           o_flags_q,
    output logic                 o_flags_valid,
    output logic                 o_branch_valid,
    input  logic                 i_branch_ready,
    output logic                 o_branch_taken,
    output logic                 o_cond_error,
    output logic [CNT_WIDTH-1:0] o_cmp_count
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EVAL = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]           r_state;
    logic [2:0]           r_flags;
    logic [2:0]           r_cond;
    logic                 r_flags_valid;
    logic                 r_branch_valid;
    logic                 r_branch_taken;
    logic                 r_cond_error;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 w_xfer;
    logic [2:0]           w_new;
    logic                 w_cond;
    logic                 w_taken;

    assign w_xfer = i_cmp_valid && (r_state == IDLE);
    assign w_new  = {i_cmp_greater, i_cmp_lower, i_cmp_equal};

    always_comb begin
        w_cond = 1'b0;
        case (r_cond)
            3'd0: w_cond = r_flags[0];
            3'd1: w_cond = !r_flags[0];
            3'd2: w_cond = r_flags[1];
            3'd3: w_cond = r_flags[2] || r_flags[0];
            3'd4: w_cond = r_flags[2];
            3'd5: w_cond = r_flags[1] || r_flags[0];
            3'd6: w_cond = 1'b1;
            default: w_cond = 1'b0;
        endcase
    end

    // an invalid triple suppresses every condition, ALWAYS included
    assign w_taken = w_cond && $onehot(r_flags);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_flags        <= 3'b000;
            r_cond         <= 3'b000;
            r_flags_valid  <= 1'b0;
            r_branch_valid <= 1'b0;
            r_branch_taken <= 1'b0;
            r_cond_error   <= 1'b0;
            r_count        <= '0;
        end else begin
            if (w_xfer) begin
                r_flags       <= w_new;
                r_cond        <= i_cond_code;
                r_flags_valid <= 1'b1;
                r_cond_error  <= (r_cond_error && !i_flag_clear) || !$onehot(w_new);
            end else if (i_flag_clear) begin
                r_flags       <= 3'b000;
                r_flags_valid <= 1'b0;
                r_cond_error  <= 1'b0;
            end
            if (w_xfer && (r_count != '1))
                r_count <= r_count + CNT_WIDTH'(1);
            case (r_state)
                IDLE: if (w_xfer) r_state <= EVAL;
                EVAL: begin
                    r_branch_taken <= w_taken;
                    r_branch_valid <= 1'b1;
                    r_state        <= HOLD;
                end
                HOLD: if (i_branch_ready) begin
                    r_branch_valid <= 1'b0;
                    r_state        <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_cmp_ready    = (r_state == IDLE);
    assign o_flags_q      = r_flags;
    assign o_flags_valid  = r_flags_valid;
    assign o_branch_valid = r_branch_valid;
    assign o_branch_taken = r_branch_taken;
    assign o_cond_error   = r_cond_error;
    assign o_cmp_count    = r_count;
endmodule

// File: tb/tb_cmp_flag_unit.sv
// tb_cmp_flag_unit: directed and randomized checks of cmp_flag_unit against a transaction-level model.
module tb_cmp_flag_unit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmp_valid = 1'b0;
    logic       cmp_equal = 1'b0;
    logic       cmp_lower = 1'b0;
    logic       cmp_greater = 1'b0;
    logic [2:0] cond_code = 3'b000;
    logic       flag_clear = 1'b0;
    logic       branch_ready = 1'b0;
    logic       cmp_ready;
    logic [2:0] flags_q;
    logic       flags_valid;
    logic       branch_valid;
    logic       branch_taken;
    logic       cond_error;
    logic [7:0] cmp_count;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    cmp_flag_unit #(.CNT_WIDTH(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_cmp_valid(cmp_valid),
        .o_cmp_ready(cmp_ready),
        .i_cmp_equal(cmp_equal),
        .i_cmp_lower(cmp_lower),
        .i_cmp_greater(cmp_greater),
        .i_cond_code(cond_code),
        .i_flag_clear(flag_clear),
        .o_flags_q(flags_q),
        .o_flags_valid(flags_valid),
        .o_branch_valid(branch_valid),
        .i_branch_ready(branch_ready),
        .o_branch_taken(branch_taken),
        .o_cond_error(cond_error),
        .o_cmp_count(cmp_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // branch outcome decided at capture time from the comparison semantics
    function automatic bit expect_taken(input bit [2:0] f, input bit [2:0] c);
        bit eq, lt, gt;
        eq = f[0];
        lt = f[1];
        gt = f[2];
        if (int'(f[0]) + int'(f[1]) + int'(f[2]) != 1) return 1'b0;
        case (c)
            3'd0: return eq;
            3'd1: return !eq;
            3'd2: return lt;
            3'd3: return !lt;
            3'd4: return gt;
            3'd5: return !gt;
            3'd6: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    bit       m_busy, m_bv, m_bt, m_pend, m_fv, m_err;
    bit [2:0] m_flags;
    int       m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_bv = 0; m_bt = 0; m_pend = 0; m_fv = 0; m_err = 0;
            m_flags = 3'b000; m_cnt = 0;
        end else begin
            bit old_busy;
            bit [2:0] f;
            old_busy = m_busy;
            f = {cmp_greater, cmp_lower, cmp_equal};
            if (old_busy) begin
                if (!m_bv) begin
                    m_bv = 1;
                    m_bt = m_pend;
                end else if (branch_ready) begin
                    m_bv = 0;
                    m_busy = 0;
                end
            end
            if (cmp_valid && !old_busy) begin
                m_err = (flag_clear ? 1'b0 : m_err) | (int'(f[0]) + int'(f[1]) + int'(f[2]) != 1);
                m_flags = f;
                m_fv = 1;
                m_pend = expect_taken(f, cond_code);
                m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                m_busy = 1;
            end else if (flag_clear) begin
                m_flags = 3'b000;
                m_fv = 0;
                m_err = 0;
            end
        end
    end

    always @(negedge clk) begin
        check("m_cmp_ready", cmp_ready, !m_busy);
        check("m_flags_q", flags_q, m_flags);
        check("m_flags_valid", flags_valid, m_fv);
        check("m_branch_valid", branch_valid, m_bv);
        check("m_branch_taken", branch_taken, m_bt);
        check("m_cond_error", cond_error, m_err);
        check("m_cmp_count", cmp_count, m_cnt);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit [2:0] f, input bit [2:0] c);
        {cmp_greater, cmp_lower, cmp_equal} = f;
        cond_code = c;
        cmp_valid = 1'b1;
        step;
        cmp_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_lt;
        exp_lt = 8'b01100110;
        step;
        step;
        check("rst_ready", cmp_ready, 1);
        check("rst_count", cmp_count, 0);
        check("rst_bv", branch_valid, 0);
        rst_n = 1'b1;
        branch_ready = 1'b1;
        send(3'b001, 3'd0);
        check("eq_flags", flags_q, 3'b001);
        check("eq_count", cmp_count, 1);
        check("eq_bv_early", branch_valid, 0);
        check("eq_ready_busy", cmp_ready, 0);
        step;
        check("eq_bv", branch_valid, 1);
        check("eq_taken", branch_taken, 1);
        step;
        check("eq_bv_done", branch_valid, 0);
        check("eq_ready_back", cmp_ready, 1);
        for (int c = 0; c < 8; c++) begin
            send(3'b010, c[2:0]);
            step;
            check($sformatf("lt_taken_cc%0d", c), branch_taken, exp_lt[c]);
            step;
        end
        branch_ready = 1'b0;
        send(3'b100, 3'd4);
        step;
        for (int i = 0; i < 5; i++) begin
            cmp_valid = (i == 2);
            step;
            cmp_valid = 1'b0;
            check("hold_bv", branch_valid, 1);
            check("hold_taken", branch_taken, 1);
            check("hold_ready", cmp_ready, 0);
            check("hold_count", cmp_count, 10);
        end
        branch_ready = 1'b1;
        step;
        check("hold_release", branch_valid, 0);
        send(3'b011, 3'd6);
        check("bad_err", cond_error, 1);
        check("bad_flags", flags_q, 3'b011);
        step;
        check("bad_taken", branch_taken, 0);
        flag_clear = 1'b1;
        step;
        flag_clear = 1'b0;
        check("clr_err", cond_error, 0);
        check("clr_flags", flags_q, 0);
        check("clr_fv", flags_valid, 0);
        send(3'b000, 3'd6);
        step;
        step;
        flag_clear = 1'b1;
        send(3'b001, 3'd0);
        flag_clear = 1'b0;
        check("coin_err", cond_error, 0);
        check("coin_flags", flags_q, 3'b001);
        check("coin_fv", flags_valid, 1);
        check("coin_count", cmp_count, 13);
        step;
        step;
        repeat (260) begin
            send(3'b100, 3'd4);
            step;
            step;
        end
        check("sat_count", cmp_count, 255);
        branch_ready = 1'b0;
        send(3'b001, 3'd0);
        step;
        check("rh_bv_before", branch_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rh_bv", branch_valid, 0);
        check("rh_taken", branch_taken, 0);
        check("rh_ready", cmp_ready, 1);
        check("rh_flags", flags_q, 0);
        check("rh_count", cmp_count, 0);
        step;
        step;
        rst_n = 1'b1;
        branch_ready = 1'b1;
        repeat (3) begin
            step;
            check("rh_no_bv", branch_valid, 0);
        end
        repeat (3000) begin
            cmp_valid = 1'($urandom);
            {cmp_greater, cmp_lower, cmp_equal} = 3'($urandom);
            cond_code = 3'($urandom);
            flag_clear = ($urandom_range(0, 7) == 0);
            branch_ready = ($urandom_range(0, 2) != 0);
            rst_n = ($urandom_range(0, 299) != 0);
            step;
        end
        rst_n = 1'b1;
        step;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
